// File: rtl/cmsdk_fpga_sram_arb_pkg.sv
// Shared types and helpers for the two-port SRAM arbiter.
// The optional grant statistics are enabled by defining CMSDK_FPGA_SRAM_ARB_STATS_EN.
package cmsdk_fpga_sram_arb_pkg;

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } arb_state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    // Width that can hold every value 0..max_burst of the burst counter.
    function automatic int bcnt_width(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/cmsdk_fpga_sram_arb_rr.sv
// Two-way round-robin picker: a lone requester wins, on contention the port
// that was not granted last wins. Purely combinational, one-hot output.
module cmsdk_fpga_sram_arb_rr
    import cmsdk_fpga_sram_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic [1:0] o_gnt
);

    // NOTE: every output gets a default before any branch so no path can infer a latch.
    always_comb begin
        o_gnt = i_req;
        if (i_req[0] && i_req[1]) begin
            o_gnt = (i_last == PORT1) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/cmsdk_fpga_sram_arb.sv
// Round-robin arbiter sharing one single-port block RAM between two word requesters,
// with bounded burst locking. Grant counters built only with CMSDK_FPGA_SRAM_ARB_STATS_EN.
module cmsdk_fpga_sram_arb
    import cmsdk_fpga_sram_arb_pkg::*;
#(
    parameter int AW        = 16,
    parameter int MAX_BURST = 4
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_req0,
    input  logic          i_req1,
    input  logic          i_lock0,
    input  logic          i_lock1,
    input  logic          i_write0,
    input  logic          i_write1,
    input  logic [AW-3:0] i_addr0,
    input  logic [AW-3:0] i_addr1,
    input  logic [31:0]   i_wdata0,
    input  logic [31:0]   i_wdata1,
    input  logic [3:0]    i_wstrb0,
    input  logic [3:0]    i_wstrb1,
    output logic          o_gnt0,
    output logic          o_gnt1,
    output logic          o_rvalid0,
    output logic          o_rvalid1,
    output logic [31:0]   o_rdata0,
    output logic [31:0]   o_rdata1,
    output logic          o_sram_cs,
    output logic [AW-3:0] o_sram_addr,
    output logic [31:0]   o_sram_wdata,
    output logic [3:0]    o_sram_wren,
    input  logic [31:0]   i_sram_rdata,
    output logic [31:0]   o_gnt_cnt0,
    output logic [31:0]   o_gnt_cnt1
);

    localparam int              BW       = bcnt_width(MAX_BURST);
    localparam logic [BW-1:0]   BCNT_MAX = BW'(MAX_BURST);
    localparam logic            LOCK_EN  = (MAX_BURST > 1);

    arb_state_t     r_state;
    arb_state_t     w_state_nxt;
    logic           r_last;
    logic           w_last_nxt;
    logic [BW-1:0]  r_bcnt;
    logic [BW-1:0]  w_bcnt_nxt;
    logic [BW-1:0]  w_bcnt_inc;
    logic           r_rpend;
    logic           r_rsel;

    logic [1:0]     w_rr_gnt;
    logic [1:0]     w_gnt;
    logic           w_any;
    logic           w_win;
    logic           w_win_lock;
    logic           w_win_write;
    logic           w_held;

    cmsdk_fpga_sram_arb_rr u_rr (
        .i_req  ({i_req1, i_req0}),
        .i_last (r_last),
        .o_gnt  (w_rr_gnt)
    );

    // A lock owner that drops its request hands the cycle straight back to the picker.
    always_comb begin
        w_gnt = 2'b00;
        if (!i_reset) begin
            if (r_state == ST_LOCK0 && i_req0) begin
                w_gnt = 2'b01;
            end else if (r_state == ST_LOCK1 && i_req1) begin
                w_gnt = 2'b10;
            end else begin
                w_gnt = w_rr_gnt;
            end
        end
    end

    assign w_any       = |w_gnt;
    assign w_win       = w_gnt[1];
    assign w_win_lock  = w_win ? i_lock1  : i_lock0;
    assign w_win_write = w_win ? i_write1 : i_write0;
    assign w_held      = (r_state == ST_LOCK0 && w_gnt[0]) || (r_state == ST_LOCK1 && w_gnt[1]);
    assign w_bcnt_inc  = r_bcnt + 1'b1;

    always_comb begin
        w_state_nxt = ST_ARB;
        w_last_nxt  = r_last;
        w_bcnt_nxt  = '0;
        if (w_any) begin
            w_last_nxt = w_win;
            if (w_held) begin
                if (w_win_lock && w_bcnt_inc != BCNT_MAX) begin
                    w_state_nxt = r_state;
                    w_bcnt_nxt  = w_bcnt_inc;
                end
            end else if (w_win_lock && LOCK_EN) begin
                w_state_nxt = w_win ? ST_LOCK1 : ST_LOCK0;
                w_bcnt_nxt  = BW'(1);
            end
        end
    end

    // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_ARB;
            r_last  <= PORT1;
            r_bcnt  <= '0;
            r_rpend <= 1'b0;
            r_rsel  <= PORT0;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            r_bcnt  <= w_bcnt_nxt;
            r_rpend <= w_any && !w_win_write;
            r_rsel  <= w_win;
        end
    end

    assign o_gnt0       = w_gnt[0];
    assign o_gnt1       = w_gnt[1];
    assign o_sram_cs    = w_any;
    assign o_sram_addr  = w_win ? i_addr1  : i_addr0;
    assign o_sram_wdata = w_win ? i_wdata1 : i_wdata0;
    assign o_sram_wren  = (w_any && w_win_write) ? (w_win ? i_wstrb1 : i_wstrb0) : 4'h0;

    assign o_rvalid0 = r_rpend && (r_rsel == PORT0);
    assign o_rvalid1 = r_rpend && (r_rsel == PORT1);
    assign o_rdata0  = o_rvalid0 ? i_sram_rdata : 32'h0;
    assign o_rdata1  = o_rvalid1 ? i_sram_rdata : 32'h0;

`ifdef CMSDK_FPGA_SRAM_ARB_STATS_EN
    logic [31:0] r_gnt_cnt0;
    logic [31:0] r_gnt_cnt1;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_gnt_cnt0 <= '0;
            r_gnt_cnt1 <= '0;
        end else begin
            if (w_gnt[0]) r_gnt_cnt0 <= sat_inc(r_gnt_cnt0);
            if (w_gnt[1]) r_gnt_cnt1 <= sat_inc(r_gnt_cnt1);
        end
    end

    assign o_gnt_cnt0 = r_gnt_cnt0;
    assign o_gnt_cnt1 = r_gnt_cnt1;
`else
    assign o_gnt_cnt0 = 32'h0;
    assign o_gnt_cnt1 = 32'h0;
`endif

endmodule

// File: tb/tb_cmsdk_fpga_sram_arb.sv
// Self-checking bench for cmsdk_fpga_sram_arb: directed table, corner sequences and
// random traffic against a transaction-level model with its own memory image.
module tb_cmsdk_fpga_sram_arb;

    localparam int AW        = 16;
    localparam int MAX_BURST = 4;
    localparam int WAW       = AW - 2;
`ifdef CMSDK_FPGA_SRAM_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic req0, req1, lock0, lock1, write0, write1;
    logic [WAW-1:0] addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic [3:0]  wstrb0, wstrb1;
    logic gnt0, gnt1, rvalid0, rvalid1, sram_cs;
    logic [31:0] rdata0, rdata1, sram_wdata, sram_rdata, gnt_cnt0, gnt_cnt1;
    logic [WAW-1:0] sram_addr;
    logic [3:0]  sram_wren;

    always #5 clk = ~clk;

    cmsdk_fpga_sram_arb #(.AW(AW), .MAX_BURST(MAX_BURST)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_req0(req0), .i_req1(req1), .i_lock0(lock0), .i_lock1(lock1),
        .i_write0(write0), .i_write1(write1), .i_addr0(addr0), .i_addr1(addr1),
        .i_wdata0(wdata0), .i_wdata1(wdata1), .i_wstrb0(wstrb0), .i_wstrb1(wstrb1),
        .o_gnt0(gnt0), .o_gnt1(gnt1), .o_rvalid0(rvalid0), .o_rvalid1(rvalid1),
        .o_rdata0(rdata0), .o_rdata1(rdata1), .o_sram_cs(sram_cs), .o_sram_addr(sram_addr),
        .o_sram_wdata(sram_wdata), .o_sram_wren(sram_wren), .i_sram_rdata(sram_rdata),
        .o_gnt_cnt0(gnt_cnt0), .o_gnt_cnt1(gnt_cnt1)
    );

    // Block RAM behaviour: byte-enabled write, registered read, one-cycle latency.
    logic [31:0] sram_mem [0:(1<<WAW)-1];
    always @(posedge clk) begin
        if (sram_cs) begin
            for (int b = 0; b < 4; b++)
                if (sram_wren[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
            sram_rdata <= sram_mem[sram_addr];
        end
    end

    // Reference model: lock owner (-1 none), grants taken in the current burst, last winner.
    int m_owner = -1;
    int m_burst = 0;
    int m_last  = 1;
    bit m_rpend = 1'b0;
    int m_rport = 0;
    logic [31:0] m_rdata = 32'h0;
    logic [31:0] m_mem [int];
    int m_cnt0 = 0;
    int m_cnt1 = 0;
    int last_win = -1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_rd(input int a);
        return m_mem.exists(a) ? m_mem[a] : 32'h0;
    endfunction

    function automatic int pick_winner();
        if (rst) return -1;
        if (m_owner == 0 && req0) return 0;
        if (m_owner == 1 && req1) return 1;
        if (req0 && req1) return 1 - m_last;
        if (req0) return 0;
        if (req1) return 1;
        return -1;
    endfunction

    // Inputs are set just after a rising edge; compare mid-cycle, then advance the model.
    task automatic cycle();
        int win;
        logic lk, e_write;
        logic [WAW-1:0] e_addr;
        logic [31:0] e_wdata, word;
        logic [3:0] e_wren;
        #3;
        win     = pick_winner();
        e_addr  = (win == 1) ? addr1  : addr0;
        e_wdata = (win == 1) ? wdata1 : wdata0;
        e_write = (win == 1) ? write1 : write0;
        lk      = (win == 1) ? lock1  : lock0;
        e_wren  = (win >= 0 && e_write) ? ((win == 1) ? wstrb1 : wstrb0) : 4'h0;
        check("grant", {gnt0, gnt1}, {win == 0, win == 1});
        check("sram_drive", {sram_cs, sram_wren, sram_addr, sram_wdata}, {win >= 0, e_wren, e_addr, e_wdata});
        check("read_return", {rvalid0, rvalid1, rdata0, rdata1},
              {m_rpend && m_rport == 0, m_rpend && m_rport == 1,
               (m_rpend && m_rport == 0) ? m_rdata : 32'h0, (m_rpend && m_rport == 1) ? m_rdata : 32'h0});
        last_win = win;
        @(posedge clk);
        if (rst) begin
            m_owner = -1; m_burst = 0; m_last = 1; m_rpend = 1'b0; m_cnt0 = 0; m_cnt1 = 0;
        end else begin
            m_rpend = 1'b0;
            if (win >= 0) begin
                if (win == 0) m_cnt0++; else m_cnt1++;
                if (e_write) begin
                    word = mem_rd(int'(e_addr));
                    for (int b = 0; b < 4; b++)
                        if (e_wren[b]) word[8*b +: 8] = e_wdata[8*b +: 8];
                    m_mem[int'(e_addr)] = word;
                end else begin
                    m_rpend = 1'b1; m_rport = win; m_rdata = mem_rd(int'(e_addr));
                end
                if (m_owner == win) begin
                    m_burst++;
                    if (!lk || m_burst == MAX_BURST) begin m_owner = -1; m_burst = 0; end
                end else if (lk && MAX_BURST > 1) begin
                    m_owner = win; m_burst = 1;
                end else begin
                    m_owner = -1; m_burst = 0;
                end
                m_last = win;
            end else begin
                m_owner = -1; m_burst = 0;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        req0 = 0; req1 = 0; lock0 = 0; lock1 = 0; write0 = 0; write1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; wstrb0 = '0; wstrb1 = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    typedef struct packed {
        logic r0, r1, l0, l1;
        logic g0, g1;
    } vec_t;
    vec_t vecs [28];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1,1,0,0, 1,0}; vecs[1]  = '{1,1,0,0, 0,1}; vecs[2]  = '{1,1,0,0, 1,0};
        vecs[3]  = '{1,1,0,0, 0,1}; vecs[4]  = '{0,0,0,0, 0,0}; vecs[5]  = '{1,0,0,0, 1,0};
        vecs[6]  = '{1,0,0,0, 1,0}; vecs[7]  = '{1,1,0,0, 0,1}; vecs[8]  = '{1,1,0,1, 1,0};
        vecs[9]  = '{1,1,0,1, 0,1}; vecs[10] = '{1,1,0,1, 0,1}; vecs[11] = '{1,1,0,1, 0,1};
        vecs[12] = '{1,1,0,1, 0,1}; vecs[13] = '{1,1,0,1, 1,0}; vecs[14] = '{0,1,0,1, 0,1};
        vecs[15] = '{1,0,0,0, 1,0}; vecs[16] = '{0,1,0,1, 0,1}; vecs[17] = '{1,1,0,0, 0,1};
        vecs[18] = '{1,1,0,0, 1,0}; vecs[19] = '{0,1,0,1, 0,1}; vecs[20] = '{0,1,0,1, 0,1};
        vecs[21] = '{0,1,0,1, 0,1}; vecs[22] = '{0,1,0,1, 0,1}; vecs[23] = '{0,1,0,1, 0,1};
        vecs[24] = '{1,1,1,0, 0,1}; vecs[25] = '{1,1,1,0, 1,0}; vecs[26] = '{1,1,0,0, 1,0};
        vecs[27] = '{1,1,0,0, 0,1};

        rst = 1'b1;
        idle_inputs();
        @(posedge clk); #1;
        do_reset();

        #2;
        check("reset_state", {gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, sram_cs, sram_wren, gnt_cnt0, gnt_cnt1}, 128'h0);
        cycle();

        // Full write then read of the same word.
        req0 = 1; write0 = 1; addr0 = 14'h10; wdata0 = 32'hDEADBEEF; wstrb0 = 4'hF;
        cycle();
        write0 = 0;
        cycle();
        req0 = 0;
        #2;
        check("readback_full", {rvalid0, rvalid1, rdata0}, {1'b1, 1'b0, 32'hDEADBEEF});
        cycle();

        // Single-byte merge into an existing word.
        req0 = 1; write0 = 1; addr0 = 14'h20; wdata0 = 32'h11223344; wstrb0 = 4'hF;
        cycle();
        wdata0 = 32'h0000AA00; wstrb0 = 4'h2;
        #2;
        check("partial_wren", sram_wren, 4'h2);
        cycle();
        write0 = 0;
        cycle();
        req0 = 0;
        #2;
        check("readback_partial", {rvalid0, rdata0}, {1'b1, 32'h1122AA44});
        cycle();

        // Known contents for the random region.
        req1 = 1; write1 = 1; wstrb1 = 4'hF;
        for (int i = 0; i < 8; i++) begin
            addr1 = WAW'(14'h40 + i); wdata1 = $urandom;
            cycle();
        end
        idle_inputs();

        // Arbitration table from a fresh reset.
        do_reset();
        addr0 = 14'h10; addr1 = 14'h20;
        for (int i = 0; i < 28; i++) begin
            req0 = vecs[i].r0; req1 = vecs[i].r1; lock0 = vecs[i].l0; lock1 = vecs[i].l1;
            #2;
            check($sformatf("table_gnt[%0d]", i), {gnt0, gnt1}, {vecs[i].g0, vecs[i].g1});
            cycle();
        end
        idle_inputs();

        // Random mixed traffic; an ungranted requester keeps its request unchanged.
        for (int i = 0; i < 600; i++) begin
            if (!(req0 && last_win != 0)) begin
                req0 = ($urandom_range(0, 3) != 0); lock0 = $urandom_range(0, 1);
                write0 = $urandom_range(0, 1); addr0 = WAW'(14'h40 + $urandom_range(0, 7));
                wdata0 = $urandom; wstrb0 = 4'($urandom_range(0, 15));
            end
            if (!(req1 && last_win != 1)) begin
                req1 = ($urandom_range(0, 3) != 0); lock1 = $urandom_range(0, 1);
                write1 = $urandom_range(0, 1); addr1 = WAW'(14'h40 + $urandom_range(0, 7));
                wdata1 = $urandom; wstrb1 = 4'($urandom_range(0, 15));
            end
            cycle();
        end
        idle_inputs();
        #2;
        check("random_gnt_cnt", {gnt_cnt0, gnt_cnt1},
              STATS ? {32'(m_cnt0), 32'(m_cnt1)} : 64'h0);
        cycle();

        // Read granted under lock, then reset while it is outstanding.
        req1 = 1; lock1 = 1; write1 = 0; addr1 = 14'h41;
        cycle();
        rst = 1; req0 = 1;
        cycle();
        rst = 0; lock1 = 0;
        #2;
        check("post_reset", {rvalid0, rvalid1, gnt0, gnt1}, 4'b0010);
        cycle();
        idle_inputs();
        cycle();

        // Grant counters: ten grants to port 0, three to port 1.
        do_reset();
        req0 = 1; addr0 = 14'h10;
        for (int i = 0; i < 10; i++) cycle();
        req0 = 0; req1 = 1; addr1 = 14'h20;
        for (int i = 0; i < 3; i++) cycle();
        req1 = 0;
        #2;
        check("gnt_cnt", {gnt_cnt0, gnt_cnt1}, STATS ? {32'd10, 32'd3} : 64'h0);
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cmsdk_fpga_sram_arb.md
# cmsdk_fpga_sram_arb

Two-port arbiter that shares one single-port FPGA block-RAM SRAM (one-cycle read latency, per-byte write enables) between two word-access requesters, e.g. processor data path and a DMA engine. Grants at most one access per cycle using round-robin priority, with an optional bounded lock for back-to-back bursts. Read data is routed back to the requester that issued the read, one cycle after the grant.

## Interface
- AW, 16: byte address width of the SRAM; word address is [AW-1:2].
- MAX_BURST, 4: maximum consecutive grants one port may hold under lock; legal 1..16. A value of 1 disables locking.

- CLK  in  1  clock; all state on rising edge.
- RESET  in  1  synchronous, active-high reset.
- REQ0 / REQ1  in  1  access request, port n.
- LOCK0 / LOCK1  in  1  request to keep ownership after this grant.
- WRITE0 / WRITE1  in  1  1 = write, 0 = read.
- ADDR0 / ADDR1  in  AW-2  word address [AW-1:2].
- WDATA0 / WDATA1  in  32  write data.
- WSTRB0 / WSTRB1  in  4  byte strobes; ignored for reads.
- GNT0 / GNT1  out  1  access accepted this cycle (combinational).
- RVALID0 / RVALID1  out  1  RDATAn valid this cycle.
- RDATA0 / RDATA1  out  32  read data; zero when RVALIDn low.
- SRAM_CS  out  1  SRAM chip select.
- SRAM_ADDR  out  AW-2  SRAM word address.
- SRAM_WDATA  out  32  SRAM write data.
- SRAM_WREN  out  4  SRAM byte write enables.
- SRAM_RDATA  in  32  SRAM read data (valid cycle after CS).
- GNT_CNT0 / GNT_CNT1  out  32  grant counters (see Configuration).

## Operation
- States: ARB, LOCK0, LOCK1. Reset: state ARB, last-grant pointer LAST=1, burst counter BCNT=0.
- ARB: one requester -> grant it. Both -> grant port != LAST. Neither -> no grant.
- On grant to port n: LAST<=n. If LOCKn=1 and MAX_BURST>1 -> state LOCKn, BCNT<=1; else stay ARB.
- LOCKn: only port n may be granted while REQn=1. Grant -> BCNT+1. If LOCKn=0 or BCNT+1==MAX_BURST -> ARB, BCNT<=0.
- LOCKn with REQn=0: lock released this cycle; ARB rules apply same cycle (other port may win); state -> ARB or LOCKother.
- SRAM drive: SRAM_CS=GNT0|GNT1; SRAM_ADDR/WDATA muxed from winner; SRAM_WREN=WSTRBn when winner writes, else 0. No winner: CS=0, WREN=0, ADDR/WDATA hold port 0 values.
- Read return: registered RSEL/RPEND = granted read and its port; RVALIDn = RPEND & (RSEL==n); RDATAn = SRAM_RDATA gated by RVALIDn.
- Writes: no response; complete at grant edge. Read of same word granted next cycle returns new data.

## Timing
- GNTn combinational from REQ/LOCK/state in the same cycle; requester holds all request signals stable while REQn=1 and GNTn=0.
- Read latency: grant cycle T -> RVALIDn/RDATAn in T+1. Throughput one access per cycle, reads and writes mixed freely.
- Reset values: GNT0/1=0, RVALID0/1=0, RDATA0/1=0, SRAM_CS=0, SRAM_WREN=0, GNT_CNT0/1=0. RESET high forces no grant regardless of REQ.
- Reset during outstanding read: RVALID cleared next edge; data dropped.
- MAX_BURST reached while other port idle: returns to ARB; owner may be regranted immediately (single requester wins).

## Configuration
- CMSDK_FPGA_SRAM_ARB_STATS_EN defined: GNT_CNTn increments on each GNTn, saturates at 0xFFFFFFFF, cleared by RESET.
- Not defined: counters not built; GNT_CNT0/1 tied to 0.

## Structure
- Package cmsdk_fpga_sram_arb_pkg: state enum (ARB, LOCK0, LOCK1), port index constants, BCNT width function ($clog2(MAX_BURST+1)).
- Sub-module cmsdk_fpga_sram_arb_rr: 2-way round-robin picker (REQ, LAST -> one-hot grant), combinational.

## Test plan
- Both REQ steady, LOCK=0, after reset -> grants 0,1,0,1...; SRAM_CS=1 every cycle.
- Port0 writes 0xDEADBEEF WSTRB=0xF to word 0x10, then reads 0x10 -> RVALID0 next cycle, RDATA0=0xDEADBEEF, RVALID1=0.
- Write WSTRB=0x2 data 0x0000AA00 over 0x11223344 -> readback 0x1122AA44.
- MAX_BURST=4, port1 LOCK1=1 continuous, port0 requesting -> 4 grants to port1, then port0 granted, GNT0 never during lock.
- Read granted, RESET asserted next cycle -> RVALID0/1=0, SRAM_CS=0, state ARB, first post-reset contention grants port0.
- STATS_EN, 10 grants port0, 3 port1 -> GNT_CNT0=10, GNT_CNT1=3; undefined -> both 0.
